// File: rtl/pc_pkg.sv
//==============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the program-counter unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        SRC_EXC  = 3'd0,
        SRC_ERET = 3'd1,
        SRC_HOLD = 3'd2,
        SRC_JR   = 3'd3,
        SRC_J    = 3'd4,
        SRC_BR   = 3'd5,
        SRC_SEQ  = 3'd6
    } pc_src_t;

    localparam int JIDX_W = 26;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
//==============================================================================
// Module      : pc_next_sel
// Description : Combinational next-PC source priority and target computation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_next_sel
    import pc_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h0000_0080)
) (
    input  logic [WIDTH-1:0]  i_pc,
    input  logic [WIDTH-1:0]  i_pc_plus,
    input  logic [WIDTH-1:0]  i_epc,
    input  pc_state_t         i_state,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic              i_branch_ne,
    input  logic              i_zero,
    input  logic [WIDTH-1:0]  i_shift_left,
    input  logic              i_jump,
    input  logic [JIDX_W-1:0] i_jump_index,
    input  logic              i_jump_reg,
    input  logic [WIDTH-1:0]  i_reg_target,
    input  logic              i_exception,
    input  logic              i_eret,
    output pc_src_t           o_src,
    output logic [WIDTH-1:0]  o_next_pc,
    output logic              o_misalign
);

    logic [WIDTH-1:0] w_jump_target;
    logic             w_taken;

    // At the minimum width the jump field fills the whole address.
    if (WIDTH > 28) begin : g_jt_upper
        assign w_jump_target = {i_pc_plus[WIDTH-1:28], i_jump_index, 2'b00};
    end else begin : g_jt_narrow
        assign w_jump_target = {i_jump_index, 2'b00};
    end

    assign w_taken    = i_branch & (i_zero ^ i_branch_ne);
    assign o_misalign = i_jump_reg & (i_reg_target[1:0] != 2'b00);

    always_comb begin
        o_src     = SRC_SEQ;
        o_next_pc = i_pc_plus;
        if (i_exception || o_misalign) begin
            o_src     = SRC_EXC;
            o_next_pc = EXC_VEC;
        end else if (i_eret && (i_state == EXC)) begin
            o_src     = SRC_ERET;
            o_next_pc = i_epc;
        end else if (i_stall) begin
            o_src     = SRC_HOLD;
            o_next_pc = i_pc;
        end else if (i_jump_reg) begin
            o_src     = SRC_JR;
            o_next_pc = i_reg_target;
        end else if (i_jump) begin
            o_src     = SRC_J;
            o_next_pc = w_jump_target;
        end else if (w_taken) begin
            o_src     = SRC_BR;
            o_next_pc = i_pc_plus + i_shift_left;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
//==============================================================================
// Module      : pc_unit
// Description : MIPS program counter with stall, exception vector, EPC and eret.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0080),
    parameter int               INC       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              Branch,
    input  logic              branch_ne,
    input  logic              Zero,
    input  logic [WIDTH-1:0]  shift_left_in,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jump_reg,
    input  logic [WIDTH-1:0]  reg_target,
    input  logic              exception,
    input  logic              eret,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus,
    output logic [WIDTH-1:0]  epc,
    output logic              in_handler,
    output logic              addr_err
);

    localparam logic [WIDTH-1:0] c_inc = WIDTH'(INC);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_addr_err;
    pc_state_t        r_state;
    pc_state_t        w_state_next;
    pc_src_t          w_src;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_misalign;

    assign pc_plus = r_pc + c_inc;

    pc_next_sel #(
        .WIDTH   (WIDTH),
        .EXC_VEC (EXC_VEC)
    ) u_next_sel (
        .i_pc         (r_pc),
        .i_pc_plus    (pc_plus),
        .i_epc        (r_epc),
        .i_state      (r_state),
        .i_stall      (stall),
        .i_branch     (Branch),
        .i_branch_ne  (branch_ne),
        .i_zero       (Zero),
        .i_shift_left (shift_left_in),
        .i_jump       (jump),
        .i_jump_index (jump_index),
        .i_jump_reg   (jump_reg),
        .i_reg_target (reg_target),
        .i_exception  (exception),
        .i_eret       (eret),
        .o_src        (w_src),
        .o_next_pc    (w_next_pc),
        .o_misalign   (w_misalign)
    );

    always_comb begin
        w_state_next = r_state;
        if (w_src == SRC_EXC) begin
            w_state_next = EXC;
        end else if (w_src == SRC_ERET) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_next_pc;
            r_addr_err <= w_misalign;
            // A nested exception keeps the original return address.
            if ((w_src == SRC_EXC) && (r_state == RUN)) begin
                r_epc <= r_pc;
            end
        end
    end

    assign pc         = r_pc;
    assign epc        = r_epc;
    assign in_handler = (r_state == EXC);
    assign addr_err   = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//==============================================================================
// Module      : tb_pc_unit
// Description : Directed and randomized self-checking bench for pc_unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_unit;

    localparam int          c_w       = 32;
    localparam logic [31:0] c_rst_vec = 32'h0000_0000;
    localparam logic [31:0] c_exc_vec = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, Branch, branch_ne, Zero, jump, jump_reg, exception, eret;
    logic [31:0] shift_left_in, reg_target;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus, epc;
    logic        in_handler, addr_err;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] m_pc, m_epc;
    logic        m_exc, m_aerr;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH     (c_w),
        .RESET_VEC (c_rst_vec),
        .EXC_VEC   (c_exc_vec),
        .INC       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .Branch        (Branch),
        .branch_ne     (branch_ne),
        .Zero          (Zero),
        .shift_left_in (shift_left_in),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .reg_target    (reg_target),
        .exception     (exception),
        .eret          (eret),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .epc           (epc),
        .in_handler    (in_handler),
        .addr_err      (addr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b1; stall = 0; Branch = 0; branch_ne = 0; Zero = 0; jump = 0;
        jump_reg = 0; exception = 0; eret = 0;
        shift_left_in = '0; reg_target = '0; jump_index = '0;
    endtask

    // Advance the model from the rules, clock the DUT, then compare everything.
    task automatic tick(input string tag);
        logic        mis;
        logic [31:0] pp;
        pp  = m_pc + 32'd4;
        mis = jump_reg && (reg_target[1:0] != 2'b00);
        if (!rst) begin
            m_pc = c_rst_vec; m_epc = 0; m_exc = 0; m_aerr = 0;
        end else begin
            m_aerr = 0;
            if (exception || mis) begin
                if (!m_exc) begin
                    m_epc = m_pc;
                    m_exc = 1;
                end
                m_pc   = c_exc_vec;
                m_aerr = mis;
            end else if (eret && m_exc) begin
                m_pc  = m_epc;
                m_exc = 0;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (jump_reg) begin
                m_pc = reg_target;
            end else if (jump) begin
                m_pc = {pp[31:28], jump_index, 2'b00};
            end else if (Branch && (Zero != branch_ne)) begin
                m_pc = pp + shift_left_in;
            end else begin
                m_pc = pp;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_plus"}, pc_plus, m_pc + 32'd4);
        check({tag, ".epc"}, epc, m_epc);
        check({tag, ".in_handler"}, {31'd0, in_handler}, {31'd0, m_exc});
        check({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_aerr});
        idle();
    endtask

    task automatic set_pc(input logic [31:0] v);
        jump_reg = 1; reg_target = v;
        tick("set_pc");
    endtask

    initial begin
        m_pc = 'x; m_epc = 'x; m_exc = 0; m_aerr = 0;
        idle();
        @(negedge clk);

        // Reset then sequential counting
        rst = 0;
        tick("reset");
        check("reset_pc_const", pc, 32'h0);
        tick("seq1"); check("seq1_const", pc, 32'h4);
        tick("seq2"); check("seq2_const", pc, 32'h8);
        tick("seq3"); check("seq3_const", pc, 32'hC);

        // beq / bne
        set_pc(32'h10);
        Branch = 1; shift_left_in = 32'h8; Zero = 1; branch_ne = 0;
        tick("beq_taken"); check("beq_taken_const", pc, 32'h1C);
        set_pc(32'h10);
        Branch = 1; shift_left_in = 32'h8; Zero = 1; branch_ne = 1;
        tick("bne_not"); check("bne_not_const", pc, 32'h14);
        set_pc(32'h10);
        Branch = 1; shift_left_in = 32'h8; Zero = 0; branch_ne = 1;
        tick("bne_taken"); check("bne_taken_const", pc, 32'h1C);

        // Jump, stalled jr, released jr
        set_pc(32'h0040_0000);
        jump = 1; jump_index = 26'h0000100;
        tick("jump"); check("jump_const", pc, 32'h400);
        jump_reg = 1; reg_target = 32'h2000; stall = 1;
        tick("jr_stall"); check("jr_stall_const", pc, 32'h400);
        jump_reg = 1; reg_target = 32'h2000;
        tick("jr"); check("jr_const", pc, 32'h2000);

        // Exception, nested exception, eret
        set_pc(32'h100);
        exception = 1;
        tick("exc"); check("exc_epc_const", epc, 32'h100);
        tick("exc_seq"); check("exc_seq_const", pc, 32'h84);
        exception = 1;
        tick("nested"); check("nested_epc_const", epc, 32'h100);
        eret = 1;
        tick("eret"); check("eret_const", pc, 32'h100);
        check("eret_inh_const", {31'd0, in_handler}, 32'd0);

        // Misaligned jr overrides stall; addr_err pulses once
        set_pc(32'h200);
        jump_reg = 1; reg_target = 32'h3002; stall = 1;
        tick("misalign"); check("misalign_aerr_const", {31'd0, addr_err}, 32'd1);
        check("misalign_epc_const", epc, 32'h200);
        tick("misalign_after"); check("aerr_drop_const", {31'd0, addr_err}, 32'd0);
        eret = 1;
        tick("misalign_eret");
        set_pc(32'h300);
        eret = 1;
        tick("eret_run"); check("eret_run_const", pc, 32'h304);

        // Wrap and reset in handler
        set_pc(32'hFFFF_FFFC);
        tick("wrap"); check("wrap_const", pc, 32'h0);
        exception = 1;
        tick("exc_before_rst");
        exception = 1; eret = 1; rst = 0;
        tick("rst_in_exc"); check("rst_in_exc_const", pc, c_rst_vec);
        check("rst_in_exc_inh", {31'd0, in_handler}, 32'd0);

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 49) != 0);
            stall         = ($urandom_range(0, 4) == 0);
            Branch        = ($urandom_range(0, 2) == 0);
            branch_ne     = $urandom_range(0, 1);
            Zero          = $urandom_range(0, 1);
            shift_left_in = {$urandom} & 32'hFFFF_FFFC;
            jump          = ($urandom_range(0, 5) == 0);
            jump_index    = 26'($urandom);
            jump_reg      = ($urandom_range(0, 5) == 0);
            reg_target    = {$urandom};
            if ($urandom_range(0, 2) != 0) reg_target[1:0] = 2'b00;
            exception     = ($urandom_range(0, 14) == 0);
            eret          = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
